hex_keypad_scanner: RTL and testbench

- Scans a 4x4 matrix hex keypad and debounces presses.
- Emits a 4-bit key code with a one-cycle valid strobe.
- Shifts accepted codes into a 16-bit, 4-digit entry register whose layout matches the 4-digit hex display data word, so it can drive that display's write port directly.
- Sits at the board input side, between the keypad pins and CPU/display logic.

---
 rtl/hex_keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_hex_keypad_scanner.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: row scan, debounce, one-cycle key strobe and 4-digit entry register.
// Optional auto-repeat while a key is held is built when KEYPAD_AUTOREPEAT_EN is defined.
module hex_keypad_scanner #(
    parameter int SCAN_CNT_WIDTH     = 12,
    parameter int DEBOUNCE_CNT_WIDTH = 16,
    parameter int REPEAT_CNT_WIDTH   = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_cols,
    input  logic        i_clr,
    output logic [3:0]  o_rows,
    output logic [3:0]  o_key,
    output logic        o_key_valid,
    output logic        o_pressed,
    output logic [15:0] o_data
);
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    cols_meta_q, cols_s_q;
    logic [1:0]                    row_q, row_d;
    logic [1:0]                    col_q, col_d;
    logic [3:0]                    pat_q, pat_d;
    logic [SCAN_CNT_WIDTH-1:0]     scan_cnt_q, scan_cnt_d;
    logic [DEBOUNCE_CNT_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]                    key_q, key_d;
    logic                          key_valid_q, key_valid_d;
    logic                          pressed_q, pressed_d;
    logic [15:0]                   data_q, data_d;

    logic       press_ok;
    logic [1:0] press_col;
    logic       accept;
    logic       rep_fire;
    logic [3:0] code;

    // A press is a single low column; none or several low columns are ignored.
    always_comb begin
        press_ok  = 1'b1;
        press_col = 2'd0;
        case (cols_s_q)
            4'b1110: press_col = 2'd0;
            4'b1101: press_col = 2'd1;
            4'b1011: press_col = 2'd2;
            4'b0111: press_col = 2'd3;
            default: press_ok  = 1'b0;
        endcase
    end

    always_comb begin
        code = 4'h0;
        case ({row_q, col_q})
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = 4'hA;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = 4'hB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = 4'hC;
            4'd12: code = 4'hE;
            4'd13: code = 4'h0;
            4'd14: code = 4'hF;
            4'd15: code = 4'hD;
            default: code = 4'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        pat_d      = pat_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        pressed_d  = pressed_q;
        accept     = 1'b0;
        case (state_q)
            ST_SCAN: begin
                scan_cnt_d = scan_cnt_q + SCAN_CNT_WIDTH'(1);
                if (scan_cnt_q == '1) begin
                    if (press_ok) begin
                        col_d     = press_col;
                        pat_d     = cols_s_q;
                        deb_cnt_d = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                deb_cnt_d = deb_cnt_q + DEBOUNCE_CNT_WIDTH'(1);
                if (cols_s_q != pat_q) begin
                    state_d    = ST_SCAN;
                    row_d      = row_q + 2'd1;
                    scan_cnt_d = '0;
                end else if (deb_cnt_q == '1) begin
                    accept    = 1'b1;
                    pressed_d = 1'b1;
                    state_d   = ST_HELD;
                end
            end
            ST_HELD: begin
                if (cols_s_q == 4'hF) begin
                    deb_cnt_d = '0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                deb_cnt_d = deb_cnt_q + DEBOUNCE_CNT_WIDTH'(1);
                if (cols_s_q != 4'hF) begin
                    state_d = ST_HELD;
                end else if (deb_cnt_q == '1) begin
                    pressed_d  = 1'b0;
                    state_d    = ST_SCAN;
                    row_d      = row_q + 2'd1;
                    scan_cnt_d = '0;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REPEAT_CNT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;

    // Runs only while held; paused through a release glitch so a bounce does not restart it.
    always_comb begin
        rep_cnt_d = '0;
        if (state_q == ST_HELD) begin
            rep_cnt_d = rep_cnt_q + REPEAT_CNT_WIDTH'(1);
        end else if (state_q == ST_RELEASE) begin
            rep_cnt_d = rep_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign rep_fire = (state_q == ST_HELD) && (rep_cnt_q == '1);
`else
    // No repeat counter; the width still appears so both builds share one parameter list.
    assign rep_fire = (REPEAT_CNT_WIDTH < 0);
`endif

    // A clear that lands on a strobe keeps the newest digit alone.
    always_comb begin
        key_valid_d = accept | rep_fire;
        key_d       = key_q;
        data_d      = data_q;
        if (key_valid_d) begin
            key_d  = code;
            data_d = i_clr ? {12'h000, code} : {data_q[11:0], code};
        end else if (i_clr) begin
            data_d = key_valid_q ? {12'h000, key_q} : 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_meta_q <= 4'hF;
            cols_s_q    <= 4'hF;
            state_q     <= ST_SCAN;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            pat_q       <= 4'hF;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            pressed_q   <= 1'b0;
            data_q      <= 16'h0000;
        end else begin
            cols_meta_q <= i_cols;
            cols_s_q    <= cols_meta_q;
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pat_q       <= pat_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            pressed_q   <= pressed_d;
            data_q      <= data_d;
        end
    end

    assign o_rows      = ~(4'b0001 << row_q);
    assign o_key       = key_q;
    assign o_key_valid = key_valid_q;
    assign o_pressed   = pressed_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner with a behavioural 4x4 keypad and an entry-register model.
`timescale 1ns/1ps
module tb_hex_keypad_scanner;
    localparam int SCAN_W  = 2;
    localparam int DEB_W   = 3;
    localparam int REP_W   = 5;
    // Release seen after 2 sync edges, one edge to enter RELEASE, then the full stable window.
    localparam int REL_LAT = (1 << DEB_W) + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_clr = 1'b0;
    logic [3:0]  i_cols;
    logic [3:0]  o_rows;
    logic [3:0]  o_key;
    logic        o_key_valid;
    logic        o_pressed;
    logic [15:0] o_data;

    logic [15:0] keys = 16'h0000;          // bit r*4+c = key (r,c) pressed
    logic [15:0] model_data = 16'h0000;
    logic [3:0]  keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};
    int          total = 0;
    int          bad = 0;
    int          strobe_cnt = 0;
    logic [3:0]  last_code = 4'h0;

    hex_keypad_scanner #(
        .SCAN_CNT_WIDTH    (SCAN_W),
        .DEBOUNCE_CNT_WIDTH(DEB_W),
        .REPEAT_CNT_WIDTH  (REP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cols     (i_cols),
        .i_clr      (i_clr),
        .o_rows     (o_rows),
        .o_key      (o_key),
        .o_key_valid(o_key_valid),
        .o_pressed  (o_pressed),
        .o_data     (o_data)
    );

    always #5 clk = ~clk;

    // Pressed switch connects its column to its row; a low row pulls the column low.
    always_comb begin
        i_cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !o_rows[r]) i_cols[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n && o_key_valid) begin
            strobe_cnt <= strobe_cnt + 1;
            last_code  <= o_key;
        end
    end

    task automatic wait_strobe(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (o_key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_measure(output int n);
        keys = 16'h0000;
        n = 0;
        while (o_pressed && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst_n = 1'b0;
        keys  = 16'h0000;
        i_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (o_rows !== 4'b1110) begin bad++; $display("FAIL reset_rows got=%b want=1110", o_rows); end
        total++; if (o_key !== 4'h0) begin bad++; $display("FAIL reset_key got=%h want=0", o_key); end
        total++; if (o_key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_key_valid); end
        total++; if (o_pressed !== 1'b0) begin bad++; $display("FAIL reset_pressed got=%b want=0", o_pressed); end
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", o_data); end
        rst_n = 1'b1;
        model_data = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            exp = ~(4'b0001 << ((i / (1 << SCAN_W)) % 4));
            total++; if (o_rows !== exp) begin bad++; $display("FAIL scan_rows cyc=%0d got=%b want=%b", i, o_rows, exp); end
            @(negedge clk);
        end
        total++; if (strobe_cnt !== 0) begin bad++; $display("FAIL idle_strobes got=%0d want=0", strobe_cnt); end
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL idle_data got=%h want=0000", o_data); end
    endtask

    task automatic test_press_hold();
        int  start;
        int  n;
        bit  ok;
        bit  frozen;
        start = strobe_cnt;
        keys[6] = 1'b1;
        wait_strobe(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_strobe got=none want=strobe"); end
        total++; if (o_key !== keymap[6]) begin bad++; $display("FAIL hold_key got=%h want=%h", o_key, keymap[6]); end
        model_data = {model_data[11:0], keymap[6]};
        total++; if (o_data !== model_data) begin bad++; $display("FAIL hold_data got=%h want=%h", o_data, model_data); end
        frozen = 1'b1;
        repeat (70) begin
            @(negedge clk);
            if (o_rows !== 4'b1101 || o_pressed !== 1'b1) frozen = 1'b0;
        end
        total++; if (!frozen) begin bad++; $display("FAIL hold_frozen got=%b/%b want=1101/1", o_rows, o_pressed); end
        release_measure(n);
        total++; if (n !== REL_LAT) begin bad++; $display("FAIL hold_release_lat got=%0d want=%0d", n, REL_LAT); end
        total++; if (o_rows !== 4'b1011) begin bad++; $display("FAIL hold_resume got=%b want=1011", o_rows); end
        total++; if (o_key !== keymap[6]) begin bad++; $display("FAIL hold_key_kept got=%h want=%h", o_key, keymap[6]); end
        total++; if (strobe_cnt - start !== 1) begin bad++; $display("FAIL hold_count got=%0d want=1", strobe_cnt - start); end
    endtask

    task automatic test_bounce();
        int start;
        int n;
        bit ok;
        start = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            keys[0] = ~keys[0];
            repeat (3) @(negedge clk);
        end
        keys[0] = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (strobe_cnt !== start) begin bad++; $display("FAIL bounce_strobes got=%0d want=0", strobe_cnt - start); end
        keys[0] = 1'b1;
        wait_strobe(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL bounce_stable got=none want=strobe"); end
        total++; if (o_key !== keymap[0]) begin bad++; $display("FAIL bounce_key got=%h want=%h", o_key, keymap[0]); end
        model_data = {model_data[11:0], keymap[0]};
        total++; if (o_data !== model_data) begin bad++; $display("FAIL bounce_data got=%h want=%h", o_data, model_data); end
        release_measure(n);
        total++; if (strobe_cnt - start !== 1) begin bad++; $display("FAIL bounce_count got=%0d want=1", strobe_cnt - start); end
    endtask

    task automatic test_clear();
        logic [3:0] key_before;
        key_before = o_key;
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        model_data = 16'h0000;
        total++; if (o_data !== 16'h0000) begin bad++; $display("FAIL clear_data got=%h want=0000", o_data); end
        total++; if (o_key !== key_before) begin bad++; $display("FAIL clear_key got=%h want=%h", o_key, key_before); end
    endtask

    task automatic test_sequence();
        int seq_idx [5] = '{1, 13, 12, 11, 14};
        int n;
        bit ok;
        for (int k = 0; k < 5; k++) begin
            keys[seq_idx[k]] = 1'b1;
            wait_strobe(200, ok);
            total++; if (!ok) begin bad++; $display("FAIL seq_strobe k=%0d got=none want=strobe", k); end
            total++; if (o_key !== keymap[seq_idx[k]]) begin bad++; $display("FAIL seq_key k=%0d got=%h want=%h", k, o_key, keymap[seq_idx[k]]); end
            model_data = {model_data[11:0], keymap[seq_idx[k]]};
            total++; if (o_data !== model_data) begin bad++; $display("FAIL seq_data k=%0d got=%h want=%h", k, o_data, model_data); end
            if (k == 4) begin
                i_clr = 1'b1;
                @(negedge clk);
                i_clr = 1'b0;
                model_data = {12'h000, keymap[seq_idx[k]]};
                total++; if (o_data !== model_data) begin bad++; $display("FAIL seq_clr_on_strobe got=%h want=%h", o_data, model_data); end
            end
            release_measure(n);
            total++; if (n > REL_LAT) begin bad++; $display("FAIL seq_release k=%0d got=%0d want<=%0d", k, n, REL_LAT); end
        end
    endtask

    task automatic test_multi();
        int         start;
        int         n;
        bit         ok;
        bit         frozen;
        logic [3:0] seen;
        start = strobe_cnt;
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        seen = 4'h0;
        repeat (100) begin
            @(negedge clk);
            seen = seen | ~o_rows;
        end
        keys = 16'h0000;
        repeat (10) @(negedge clk);
        total++; if (strobe_cnt !== start) begin bad++; $display("FAIL multi_strobes got=%0d want=0", strobe_cnt - start); end
        total++; if (seen !== 4'hF) begin bad++; $display("FAIL multi_scan got=%b want=1111", seen); end
        keys[9] = 1'b1;
        wait_strobe(200, ok);
        total++; if (!ok || o_key !== keymap[9]) begin bad++; $display("FAIL held_key got=%h want=%h", o_key, keymap[9]); end
        model_data = {model_data[11:0], keymap[9]};
        total++; if (o_data !== model_data) begin bad++; $display("FAIL held_data got=%h want=%h", o_data, model_data); end
        keys[0] = 1'b1;
        frozen = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (o_rows !== 4'b1011 || o_pressed !== 1'b1) frozen = 1'b0;
        end
        total++; if (!frozen) begin bad++; $display("FAIL held_second_frozen got=%b want=1011", o_rows); end
        release_measure(n);
        total++; if (n !== REL_LAT) begin bad++; $display("FAIL held_release_lat got=%0d want=%0d", n, REL_LAT); end
        total++; if (strobe_cnt - start !== 1) begin bad++; $display("FAIL held_second_count got=%0d want=1", strobe_cnt - start); end
    endtask

    task automatic test_random();
        int         idx;
        int         start;
        int         n;
        bit         ok;
        logic [3:0] exp_rows;
        for (int it = 0; it < 12; it++) begin
            idx = int'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) begin
                i_clr = 1'b1;
                @(negedge clk);
                i_clr = 1'b0;
                model_data = 16'h0000;
                total++; if (o_data !== model_data) begin bad++; $display("FAIL rnd_clr it=%0d got=%h want=0000", it, o_data); end
            end
            start = strobe_cnt;
            keys[idx] = 1'b1;
            wait_strobe(200, ok);
            total++; if (!ok || o_key !== keymap[idx]) begin bad++; $display("FAIL rnd_key it=%0d got=%h want=%h", it, o_key, keymap[idx]); end
            model_data = {model_data[11:0], keymap[idx]};
            total++; if (o_data !== model_data) begin bad++; $display("FAIL rnd_data it=%0d got=%h want=%h", it, o_data, model_data); end
            exp_rows = ~(4'b0001 << (idx / 4));
            total++; if (o_rows !== exp_rows) begin bad++; $display("FAIL rnd_rows it=%0d got=%b want=%b", it, o_rows, exp_rows); end
            repeat ($urandom_range(40, 5)) @(negedge clk);
            release_measure(n);
            total++; if (n !== REL_LAT) begin bad++; $display("FAIL rnd_release it=%0d got=%0d want=%0d", it, n, REL_LAT); end
            total++; if (strobe_cnt - start !== 1 || last_code !== keymap[idx]) begin bad++; $display("FAIL rnd_count it=%0d got=%0d/%h want=1/%h", it, strobe_cnt - start, last_code, keymap[idx]); end
            repeat ($urandom_range(15, 0)) @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        int start;
        bit ok;
        rst_n = 1'b0;
        keys  = 16'h0000;
        repeat (2) @(negedge clk);
        keys[0] = 1'b1;
        rst_n   = 1'b1;
        model_data = 16'h0000;
        start = strobe_cnt;
        repeat (7) @(negedge clk);
        total++; if (o_rows !== 4'b1110) begin bad++; $display("FAIL abort_in_debounce got=%b want=1110", o_rows); end
        rst_n = 1'b0;
        #1;
        total++; if (o_key_valid !== 1'b0 || o_pressed !== 1'b0) begin bad++; $display("FAIL abort_deb_out got=%b/%b want=0/0", o_key_valid, o_pressed); end
        repeat (20) @(negedge clk);
        total++; if (strobe_cnt !== start) begin bad++; $display("FAIL abort_deb_strobe got=%0d want=0", strobe_cnt - start); end
        keys = 16'h0000;
        rst_n = 1'b1;
        keys[5] = 1'b1;
        wait_strobe(200, ok);
        total++; if (!ok || o_key !== keymap[5]) begin bad++; $display("FAIL abort_hold_key got=%h want=%h", o_key, keymap[5]); end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (o_pressed !== 1'b0 || o_rows !== 4'b1110) begin bad++; $display("FAIL abort_hold_out got=%b/%b want=0/1110", o_pressed, o_rows); end
        total++; if (o_key !== 4'h0 || o_data !== 16'h0000) begin bad++; $display("FAIL abort_hold_regs got=%h/%h want=0/0000", o_key, o_data); end
        keys = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_data = 16'h0000;
        start = strobe_cnt;
        total++; if (o_rows !== 4'b1110) begin bad++; $display("FAIL abort_restart got=%b want=1110", o_rows); end
        repeat (30) @(negedge clk);
        total++; if (strobe_cnt !== start) begin bad++; $display("FAIL abort_idle got=%0d want=0", strobe_cnt - start); end
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int n;
        bit ok;
        keys[3] = 1'b1;
        wait_strobe(200, ok);
        total++; if (!ok || o_key !== keymap[3]) begin bad++; $display("FAIL rep_first got=%h want=%h", o_key, keymap[3]); end
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!o_key_valid && n < 100);
            total++; if (n !== (1 << REP_W)) begin bad++; $display("FAIL rep_period k=%0d got=%0d want=%0d", k, n, 1 << REP_W); end
            total++; if (o_key !== keymap[3]) begin bad++; $display("FAIL rep_key k=%0d got=%h want=%h", k, o_key, keymap[3]); end
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (o_key_valid !== 1'b0 || o_pressed !== 1'b0 || o_data !== 16'h0000 || o_rows !== 4'b1110) begin
            bad++; $display("FAIL rep_reset got=%b/%b/%h/%b want=0/0/0000/1110", o_key_valid, o_pressed, o_data, o_rows);
        end
        keys = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`else
        test_press_hold();
        test_bounce();
        test_clear();
        test_sequence();
        test_multi();
        test_random();
        test_reset_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
